// File: rtl/cs_to_canonical_89_pkg.sv
// Shared field constants and FSM state type for the 89-bit carry-save to
// canonical binary converter.
package cs_to_canonical_89_pkg;

  localparam int FIELD_W = 89;
  localparam int CS_W    = 90;

  localparam logic [FIELD_W-1:0] P_89 = 89'h19f393c_ffff_ffff_ffff_ffff;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADD,
    ST_SUB1,
    ST_SUB2,
    ST_DONE
  } state_t;

  function automatic int num_digits(input int digit_w);
    return (CS_W + digit_w - 1) / digit_w;
  endfunction

endpackage

// File: rtl/cs_to_canonical_89_digit_add.sv
// One digit of the serial adder: W-bit ripple add with carry-in and carry-out.
module cs2bin_digit_add #(
  parameter int W = 30
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] sum,
  output logic         co
);

  assign {co, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

endmodule

// File: rtl/cs_to_canonical_89.sv
// Digit-serial (c + s) mod p converter with fixed latency. Defining
// CS2BIN_FULL_RED_EN adds the two conditional-subtract passes.
module cs_to_canonical_89
  import cs_to_canonical_89_pkg::*;
#(
  parameter int DIGIT_W = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FIELD_W-1:0] din_c,
  input  logic [FIELD_W-1:0] din_s,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CS_W-1:0]   dout,
  output logic              busy
);

  localparam int NDIG    = num_digits(DIGIT_W);
  localparam int TOTAL_W = NDIG * DIGIT_W;
  localparam int LAST_W  = CS_W - (NDIG - 1) * DIGIT_W;
  localparam int CNT_W   = $clog2(NDIG + 1);

  localparam logic [DIGIT_W-1:0] LAST_MASK  = {DIGIT_W{1'b1}} >> (DIGIT_W - LAST_W);
  localparam logic [TOTAL_W-1:0] DIGIT_ONES = TOTAL_W'({DIGIT_W{1'b1}});
`ifdef CS2BIN_FULL_RED_EN
  // p is widened to 90 bits before inversion so bit 89 of ~p is set.
  localparam logic [TOTAL_W-1:0] NOT_P      = TOTAL_W'(~{1'b0, P_89});
  localparam logic               ADD_END_CI = 1'b1;
`else
  localparam logic               ADD_END_CI = 1'b0;
`endif

  state_t             state_q, state_d;
  logic [TOTAL_W-1:0] c_q, s_q, x_q;
  logic [CNT_W-1:0]   dig_q, dig_step;
  logic               carry_q;

  int                 sh;
  logic               last_dig;
  logic [DIGIT_W-1:0] dig_mask, add_a, add_b, add_sum;
  logic               add_co;
  logic [TOTAL_W-1:0] x_slice;
`ifdef CS2BIN_FULL_RED_EN
  logic [TOTAL_W-1:0] diff_q, diff_slice;
  logic [DIGIT_W:0]   add_full;
  logic               pass_carry;
`endif

  // Digit selection and slice write-back for the current counter position.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sh       = int'(dig_q) * DIGIT_W;
    last_dig = (dig_q == CNT_W'(NDIG - 1));
    dig_mask = last_dig ? LAST_MASK : {DIGIT_W{1'b1}};
    dig_step = last_dig ? '0 : dig_q + CNT_W'(1);
    add_a    = DIGIT_W'(c_q >> sh);
    add_b    = DIGIT_W'(s_q >> sh);
`ifdef CS2BIN_FULL_RED_EN
    if (state_q != ST_ADD) begin
      add_a = DIGIT_W'(x_q >> sh);
      add_b = DIGIT_W'(NOT_P >> sh);
    end
`endif
    x_slice = (x_q & ~(DIGIT_ONES << sh)) | (TOTAL_W'(add_sum & dig_mask) << sh);
`ifdef CS2BIN_FULL_RED_EN
    diff_slice = (diff_q & ~(DIGIT_ONES << sh)) | (TOTAL_W'(add_sum & dig_mask) << sh);
    // Carry out of bit 89, wherever it lands in a zero-padded last digit.
    add_full   = {add_co, add_sum};
    pass_carry = add_full[LAST_W];
`endif
  end

  cs2bin_digit_add #(.W(DIGIT_W)) u_add (
    .a   (add_a),
    .b   (add_b),
    .ci  (carry_q),
    .sum (add_sum),
    .co  (add_co)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_ADD;
`ifdef CS2BIN_FULL_RED_EN
      ST_ADD:  if (last_dig) state_d = ST_SUB1;
`else
      ST_ADD:  if (last_dig) state_d = ST_DONE;
`endif
      ST_SUB1: if (last_dig) state_d = ST_SUB2;
      ST_SUB2: if (last_dig) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    out_valid = (state_q == ST_DONE);
    dout      = (state_q == ST_DONE) ? x_q[CS_W-1:0] : '0;
  end

  // Both subtract passes write diff every time; only the commit to x is conditional.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q     <= '0;
      s_q     <= '0;
      x_q     <= '0;
      dig_q   <= '0;
      carry_q <= 1'b0;
`ifdef CS2BIN_FULL_RED_EN
      diff_q  <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            c_q     <= TOTAL_W'(din_c);
            s_q     <= TOTAL_W'(din_s);
            x_q     <= '0;
            dig_q   <= '0;
            carry_q <= 1'b0;
          end
        end
        ST_ADD: begin
          x_q     <= x_slice;
          dig_q   <= dig_step;
          carry_q <= last_dig ? ADD_END_CI : add_co;
        end
`ifdef CS2BIN_FULL_RED_EN
        ST_SUB1, ST_SUB2: begin
          diff_q  <= diff_slice;
          dig_q   <= dig_step;
          carry_q <= last_dig ? 1'b1 : add_co;
          if (last_dig && pass_carry) x_q <= diff_slice;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cs_to_canonical_89.md
# cs_to_canonical_89

Digit-serial carry-save-to-binary converter with final modular correction for the 89-bit prime field p = 0x19f393cffffffffffffffff. It sits directly downstream of the 89-bit cryptoprocessor wrapper. It accepts one redundant (carry, sum) operand pair as produced on dout_1/dout_2 and returns the single canonical binary value (c + s) mod p in [0, p). Latency is fixed and data-independent (constant time) so it leaks no operand information.

## Interface
- DIGIT_W, 30: adder digit width in bits; NDIG = ceil(90 / DIGIT_W); legal range 8..90.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  din_c/din_s hold a valid operand.
- in_ready  out  1  block can accept an operand; high only in IDLE.
- din_c  in  89  carry word of the redundant operand.
- din_s  in  89  sum word of the redundant operand.
- out_valid  out  1  dout holds a result.
- out_ready  in  1  consumer accepts the result.
- dout  out  90  result; bit 89 is always 0 when the reduction is compiled in.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ADD, SUB1, SUB2, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, register din_c/din_s zero-extended to 90 bits.
  - Clear the digit counter and carry, then go to ADD.
- ADD: one DIGIT_W slice per cycle, LSB first.
  - x[k] = c[k] + s[k] + carry.
  - After NDIG cycles, x = c + s, which is at most 2^90 − 2. Go to SUB1.
- SUB1 / SUB2: digit-serial x + ~p + 1 into a separate diff register, with the carry initialised to 1.
  - After NDIG cycles, the final carry-out 1 means x ≥ p: x ← diff.
  - Otherwise x is kept.
  - The diff computation and register writes happen every pass regardless of the outcome.
  - SUB1 → SUB2 → DONE.
  - Two passes suffice because 2^90 − 2 < 3p.
- DONE:
  - out_valid = 1 and dout = x.
  - On out_ready, go to IDLE.
  - While out_ready = 0, dout stays stable.
- The last digit is zero-padded when 90 is not a multiple of DIGIT_W. Pad bits must never reach dout.
- Arithmetic is unsigned modulo 2^90 within a pass. p is zero-extended to 90 bits before inversion.

## Timing
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0, busy = 0.
  - dout = 0, digit counter = 0, carry = 0.
- Latency with reduction: acceptance edge → out_valid high after exactly 3·NDIG + 1 cycles (10 at the default).
- Latency without reduction: NDIG + 1 cycles (4 at the default).
- Throughput: one operand per latency + 1 cycles when out_ready is held high. in_ready rises the cycle after the output handshake.
- Input and output handshakes never occur in the same cycle.
- in_valid outside IDLE is ignored. Inputs are sampled only on the acceptance edge.
- Reset asserted mid-operation aborts the conversion and restores all reset values on the next edge. No partial result is ever presented.
- out_valid stays high until consumed. There is no timeout.

## Configuration
- CS2BIN_FULL_RED_EN
  - Defined: SUB1 and SUB2 exist. dout is canonical in [0, p) and dout[89] = 0.
  - Undefined: ADD goes directly to DONE. dout is the plain 90-bit binary sum c + s with no modular correction. The diff register and the p constant are not synthesised.

## Structure
- The shared field package holds:
  - P_89 = 89'h19f393cffffffffffffffff.
  - The 90-bit width constant.
  - The state enum type.
- The DIGIT_W-bit ripple adder with carry-in and carry-out is the one natural sub-module: cs2bin_digit_add. It is reused for both ADD and SUB, with the B operand muxed between s-slice and ~p-slice.
- Operand slicing and the digit counter stay in the top module.

## Test plan
- c=0, s=0 → dout=0 after 10 cycles. in_ready low throughout. busy high for 10 cycles.
- c=p, s=0 → dout=0. c=p−1, s=0 → dout=0x19f393cfffffffffffffffe.
- c=2^89−1, s=2^89−1 → dout=0xc18d860000000000000000 (two subtractions taken). Latency is identical to the zero case.
- out_ready held low 5 cycles after out_valid → dout stable and in_ready=0. A new in_valid pulse in this window is ignored. The handshake on cycle 6 returns to IDLE.
- rst pulsed during SUB1 → next cycle: IDLE, out_valid=0, dout=0. A subsequent operand c=1, s=2 → dout=3.
- Build without CS2BIN_FULL_RED_EN: c=p, s=p → dout=2p=0x33e7279fffffffffffffffe after 4 cycles.
